shared_adder_scheduler: RTL and testbench
=========================================

# shared_adder_scheduler

Time-multiplexes one `ripple_carry_adder #(N)` slice between two requesters to perform wide additions of W = N*CHUNKS bits. It processes one N-bit chunk per cycle, LSB chunk first, and carries between chunks through a register. A round-robin arbiter grants the slice to one requester at a time. Results return on a single valid/ready response port tagged with the requester id. The block sits between the operand sources and any consumer that needs wide sums without paying for a W-bit ripple chain.

## Interface
- `N`, 4, width of the shared adder slice (bits per chunk).
- `CHUNKS`, 4, chunks per operand; W = N*CHUNKS; CHUNKS >= 1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 accepted on this edge when valid&ready.
- `req0_a`, `req0_b`  in  W  operands.
- `req0_cin`  in  1  carry in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  1  requester that owns the result (0/1).
- `resp_sum`  out  W  (a + b + cin) mod 2^W.
- `resp_cout`  out  1  carry out of the MSB chunk.

## Operation
- **State machine:** IDLE -> ADD -> DONE -> IDLE. Reset state is IDLE.
- **Grant computation in IDLE (combinational):**
  - Only one valid: grant goes to that requester.
  - Both valid: grant goes to the requester not equal to `last_grant`.
  - Neither valid: grant points to the requester not equal to `last_grant`.
- **Ready signals:** `reqX_ready` = (state==IDLE) & (grant==X) & !rst. Both readys are 0 in ADD and DONE. At most one ready is high at any time.
- **Accept (valid&ready edge):**
  - Latch a, b and id.
  - carry_reg <= cin; idx <= 0.
  - `last_grant` <= granted id.
  - State -> ADD.
- **ADD, per cycle:**
  - The adder sees a[idx*N +: N], b[idx*N +: N] and carry_reg.
  - sum_reg[idx*N +: N] <= adder sum; carry_reg <= adder cout; idx <= idx+1.
  - When idx==CHUNKS-1, state -> DONE and resp_cout <= adder cout.
  - The adder inputs are don't-care outside ADD.
- **DONE:**
  - `resp_valid`=1 and `resp_sum`/`resp_id`/`resp_cout` are held stable.
  - Leave for IDLE on the edge where `resp_ready`=1.
- **Output holding:** `resp_sum`, `resp_id` and `resp_cout` keep their last values after the handshake. They change only during the next operation's ADD/DONE transitions. Consumers must sample them only while `resp_valid`=1.
- **Arithmetic:** unsigned. Overflow wraps mod 2^W, with the lost bit reported in `resp_cout`.
- **Requester changes:** changes on `reqX_*` while not ready are ignored. Operands are captured only on the accept edge.
- **Reset, including mid-ADD or mid-DONE:**
  - State <- IDLE, idx <- 0, carry_reg <- 0, `last_grant` <- 1 (requester 0 wins first).
  - sum_reg <- 0, `resp_valid`=0, `resp_id`=0, `resp_sum`=0, `resp_cout`=0.
  - Any in-flight operation is discarded with no response.
  - Both readys are 0 while `rst`=1.

## Timing
- **Latency:** accept edge E0; chunk i is written at edge E(i+1). `resp_valid` is high in the cycle after edge E(CHUNKS), i.e. CHUNKS cycles after acceptance.
- **Throughput:** with `resp_ready` held 1, one operation every CHUNKS+2 cycles (1 IDLE, CHUNKS ADD, 1 DONE).
- **No overlap:** accept and response never overlap. No new request is accepted while DONE is stalled.
- **Ready timing:** `reqX_ready` depends combinationally on state, `last_grant` and both valids. `resp_valid` is a registered state decode.
- **Back-to-back accepts:** the first IDLE cycle after DONE may accept. With both requesters continuously valid, grants alternate 0,1,0,1,...

## Test plan
- **Full carry ripple:** N=4, CHUNKS=4; req0 a=0xFFFF, b=0x0001, cin=0. Expect `resp_sum`=0x0000, `resp_cout`=1, `resp_id`=0, with `resp_valid` rising exactly 4 cycles after accept.
- **Carry in across chunks:** req1 alone, a=0x0FFF, b=0x0000, cin=1. Expect `resp_sum`=0x1000, `resp_cout`=0, `resp_id`=1.
- **Contention:** req0 and req1 valid together from reset, req0 0x1234+0x1111 and req1 0x8000+0x8000. Expect:
  - First response id 0, sum 0x2345, cout 0.
  - Second response id 1, sum 0x0000, cout 1.
  - 3 operations per requester pair alternate strictly.
- **Single requester back-to-back:** req0 always valid, req1 idle. Expect req0 granted every CHUNKS+2 cycles with no starvation gaps.
- **Backpressure:** `resp_ready`=0 for 5 cycles in DONE. Expect `resp_valid`=1 and `resp_sum`/`resp_id`/`resp_cout` constant, both readys 0, and a new accept only after the `resp_ready` edge.
- **Reset mid-operation:** assert `rst` during ADD (idx=2). Expect:
  - All outputs 0 the next cycle and no response ever issued.
  - After release, a req1+req0 simultaneous request grants req0 first.

Source files
------------

// File: rtl/shared_adder_scheduler.sv
// Wide (N*CHUNKS-bit) adder built from a single shared N-bit ripple slice,
// time-multiplexed between two round-robin requesters, LSB chunk first.

module ripple_carry_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

module shared_adder_scheduler #(
  parameter int unsigned N      = 4,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [N*CHUNKS-1:0] req0_a,
  input  logic [N*CHUNKS-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [N*CHUNKS-1:0] req1_a,
  input  logic [N*CHUNKS-1:0] req1_b,
  input  logic                req1_cin,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [N*CHUNKS-1:0] resp_sum,
  output logic                resp_cout
);
  localparam int unsigned W    = N * CHUNKS;
  localparam int unsigned IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e          state, state_next;
  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic [IDXW-1:0] idx;
  logic            carry_reg;
  logic            id_reg;
  logic            last_grant;
  logic            grant_c;
  logic            accept_c;
  logic [N-1:0]    add_a_c, add_b_c, add_sum_c;
  logic            add_cout_c;

  // Round-robin: a lone requester wins, otherwise whoever did not win last.
  always_comb begin
    grant_c = ~last_grant;
    if (req0_valid && !req1_valid) begin
      grant_c = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_c = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !grant_c && !rst;
  assign req1_ready = (state == IDLE) &&  grant_c && !rst;
  assign accept_c   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign add_a_c = a_reg[idx*N +: N];
  assign add_b_c = b_reg[idx*N +: N];

  ripple_carry_adder #(.N(N)) u_slice (
    .a    (add_a_c),
    .b    (add_b_c),
    .cin  (carry_reg),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = ADD;
      ADD:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, chunk-serial accumulation and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      idx        <= '0;
      carry_reg  <= 1'b0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_cout  <= 1'b0;
    end else begin
      resp_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_reg      <= grant_c ? req1_a : req0_a;
            b_reg      <= grant_c ? req1_b : req0_b;
            carry_reg  <= grant_c ? req1_cin : req0_cin;
            id_reg     <= grant_c;
            last_grant <= grant_c;
            idx        <= '0;
          end
        end
        ADD: begin
          sum_reg[idx*N +: N] <= add_sum_c;
          carry_reg           <= add_cout_c;
          idx                 <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            resp_cout <= add_cout_c;
            resp_id   <= id_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_sum = sum_reg;
endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Randomized self-checking bench for shared_adder_scheduler against a
// plain-arithmetic round-robin / wide-add reference model.

module tb_shared_adder_scheduler;
  localparam int N      = 4;
  localparam int CHUNKS = 4;
  localparam int W      = N * CHUNKS;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_cout;
  logic [W-1:0] resp_sum;

  int   checks   = 0;
  int   failures = 0;
  logic model_lg;

  shared_adder_scheduler #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_grant(input logic v0, input logic v1);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return !model_lg;
  endfunction

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for resp_valid; cyc counts edges after the call.
  task automatic wait_resp(output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        cyc = k;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_lg = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: readys=%b required 00", {req1_ready, req0_ready});
    end
    step();
    checks++;
    if ({resp_valid, resp_id, resp_cout, resp_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b id=%b cout=%b sum=%h required all 0",
               resp_valid, resp_id, resp_cout, resp_sum);
    end
    rst = 1'b0;
    model_lg = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_grant: readys=%b required 01", {req1_ready, req0_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_ripple();
    int cyc;
    bit got;
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL ripple_ready: req0_ready=%b required 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    model_lg = 1'b0;
    wait_resp(cyc, got);
    checks++;
    if (!got || cyc != CHUNKS) begin
      failures++;
      $display("FAIL ripple_latency: got=%0d cycles=%0d required %0d", got, cyc, CHUNKS);
    end
    checks++;
    if ({resp_cout, resp_sum, resp_id} !== {1'b1, 16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL ripple_result: cout=%b sum=%h id=%b required 1/0000/0",
               resp_cout, resp_sum, resp_id);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL ripple_release: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_carry_in();
    int cyc;
    bit got;
    req1_a = 16'h0FFF; req1_b = 16'h0000; req1_cin = 1'b1; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    model_lg = 1'b1;
    wait_resp(cyc, got);
    checks++;
    if (!got || {resp_cout, resp_sum, resp_id} !== {1'b0, 16'h1000, 1'b1}) begin
      failures++;
      $display("FAIL carry_in: got=%0d cout=%b sum=%h id=%b required 0/1000/1",
               got, resp_cout, resp_sum, resp_id);
    end
    step();
  endtask

  task automatic test_contention();
    int cyc;
    bit got;
    logic g;
    logic [W:0] e;
    apply_reset();
    req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0;
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int op = 0; op < 6; op++) begin
      #1;
      g = model_grant(1'b1, 1'b1);
      checks++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL contention_grant op%0d: readys=%b required grant %0d",
                 op, {req1_ready, req0_ready}, g);
      end
      step();
      model_lg = g;
      e = g ? model_add(req1_a, req1_b, req1_cin) : model_add(req0_a, req0_b, req0_cin);
      wait_resp(cyc, got);
      checks++;
      if (!got || cyc != CHUNKS || resp_id !== g || resp_sum !== e[W-1:0]
          || resp_cout !== e[W]) begin
        failures++;
        $display("FAIL contention_resp op%0d: got=%0d cyc=%0d id=%b sum=%h cout=%b required id=%b sum=%h cout=%b",
                 op, got, cyc, resp_id, resp_sum, resp_cout, g, e[W-1:0], e[W]);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int last_acc = -1;
    int nacc = 0;
    int nresp = 0;
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'b0;
    req0_valid = 1'b1;
    for (int c = 0; c < 3 * (CHUNKS + 2); c++) begin
      #1;
      if (resp_valid === 1'b1) begin
        nresp++;
        checks++;
        if (exp_q.size() == 0 || c - last_acc != CHUNKS + 1) begin
          failures++;
          $display("FAIL b2b_resp_timing: cycle=%0d last_accept=%0d pending=%0d", c, last_acc,
                   exp_q.size());
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (resp_sum !== e[W-1:0] || resp_cout !== e[W] || resp_id !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: sum=%h cout=%b id=%b required sum=%h cout=%b id=0",
                     resp_sum, resp_cout, resp_id, e[W-1:0], e[W]);
          end
        end
      end
      if (req0_ready === 1'b1) begin
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != CHUNKS + 2) begin
            failures++;
            $display("FAIL b2b_spacing: gap=%0d required %0d", c - last_acc, CHUNKS + 2);
          end
        end
        exp_q.push_back(model_add(req0_a, req0_b, req0_cin));
        last_acc = c;
        nacc++;
        model_lg = 1'b0;
      end else begin
        req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      end
      step();
    end
    req0_valid = 1'b0;
    checks++;
    if (nacc != 3 || nresp != 3) begin
      failures++;
      $display("FAIL b2b_counts: accepts=%0d responses=%0d required 3/3", nacc, nresp);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit got;
    logic [W:0] e;
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'b1; req0_valid = 1'b1;
    resp_ready = 1'b0;
    e = model_add(req0_a, req0_b, req0_cin);
    step();
    model_lg = 1'b0;
    req0_valid = 1'b0;
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'b0; req1_valid = 1'b1;
    wait_resp(cyc, got);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (!got || resp_valid !== 1'b1 || resp_sum !== e[W-1:0] || resp_cout !== e[W]
          || resp_id !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
        failures++;
        $display("FAIL backpressure_hold k%0d: valid=%b sum=%h cout=%b id=%b readys=%b required 1/%h/%b/0/00",
                 k, resp_valid, resp_sum, resp_cout, resp_id, {req1_ready, req0_ready},
                 e[W-1:0], e[W]);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: valid=%b req1_ready=%b required 0/1",
               resp_valid, req1_ready);
    end
    e = model_add(req1_a, req1_b, req1_cin);
    step();
    model_lg = 1'b1;
    req1_valid = 1'b0;
    wait_resp(cyc, got);
    checks++;
    if (!got || resp_id !== 1'b1 || resp_sum !== e[W-1:0] || resp_cout !== e[W]) begin
      failures++;
      $display("FAIL backpressure_next: got=%0d id=%b sum=%h required id=1 sum=%h",
               got, resp_id, resp_sum, e[W-1:0]);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    int cyc;
    bit got;
    req0_a = 16'h7777; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
    step();
    model_lg = 1'b0;
    req0_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_ready: readys=%b required 00", {req1_ready, req0_ready});
    end
    step();
    checks++;
    if ({resp_valid, resp_id, resp_cout, resp_sum} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: valid=%b id=%b cout=%b sum=%h required all 0",
               resp_valid, resp_id, resp_cout, resp_sum);
    end
    rst = 1'b0;
    model_lg = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < CHUNKS + 4; k++) begin
      step();
      if (resp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_no_resp: stray responses=%0d required 0", seen);
    end
    req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 1'b0;
    req1_a = 16'h0F0F; req1_b = 16'h0001; req1_cin = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    model_lg = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(cyc, got);
    checks++;
    if (!got || resp_id !== 1'b0 || resp_sum !== 16'h0303) begin
      failures++;
      $display("FAIL midrst_first_grant: got=%0d id=%b sum=%h required id=0 sum=0303",
               got, resp_id, resp_sum);
    end
    step();
  endtask

  task automatic test_random();
    int cyc;
    bit got;
    logic v0, v1, g;
    logic [W:0] e;
    int stall;
    for (int op = 0; op < 30; op++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      req0_a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      req1_cin = 1'($urandom);
      req0_valid = v0;
      req1_valid = v1;
      #1;
      g = model_grant(v0, v1);
      checks++;
      if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL random_grant op%0d: v=%b%b readys=%b required grant %0d",
                 op, v1, v0, {req1_ready, req0_ready}, g);
      end
      if (!v0 && !v1) begin
        step();
        continue;
      end
      e = g ? model_add(req1_a, req1_b, req1_cin) : model_add(req0_a, req0_b, req0_cin);
      step();
      model_lg = g;
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      wait_resp(cyc, got);
      checks++;
      if (!got || cyc != CHUNKS || resp_id !== g || resp_sum !== e[W-1:0]
          || resp_cout !== e[W]) begin
        failures++;
        $display("FAIL random_resp op%0d: got=%0d cyc=%0d id=%b sum=%h cout=%b required id=%b sum=%h cout=%b",
                 op, got, cyc, resp_id, resp_sum, resp_cout, g, e[W-1:0], e[W]);
      end
      stall = $urandom_range(0, 3);
      resp_ready = 1'b0;
      for (int k = 0; k < stall; k++) step();
      checks++;
      if (resp_valid !== 1'b1 || resp_sum !== e[W-1:0] || {req1_ready, req0_ready} !== 2'b00)
      begin
        failures++;
        $display("FAIL random_stall op%0d: valid=%b sum=%h readys=%b required 1/%h/00",
                 op, resp_valid, resp_sum, {req1_ready, req0_ready}, e[W-1:0]);
      end
      resp_ready = 1'b1;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    model_lg = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_ripple();
    test_carry_in();
    test_contention();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
